// File: rtl/udp_pkg.sv
`default_nettype none
// ============================================================================
//  udp_pkg
// ----------------------------------------------------------------------------
//  Shared definitions for the UDP transmit packer:
//    - tx_state_t       : transmit FSM state encoding
//    - MAX_UDP_PAYLOAD  : largest payload that fits one Ethernet frame
//    - pkt_bytes_valid  : legal range/alignment test for the packet size
//  Revision: 1.0  initial release
// ============================================================================
package udp_pkg;

  // 1500-byte MTU minus 20-byte IPv4 header minus 8-byte UDP header.
  localparam int MAX_UDP_PAYLOAD = 1472;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_t;

  // Payload must be whole 32-bit words and fit in a single datagram.
  function automatic bit pkt_bytes_valid(input int pkt_bytes);
    return (pkt_bytes >= 4) && (pkt_bytes <= MAX_UDP_PAYLOAD) && ((pkt_bytes % 4) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/udp_tx_packer_if.sv
`default_nettype none
// ============================================================================
//  udp_tx_packer_if
// ----------------------------------------------------------------------------
//  Bundles the byte-sample stream and the UDP-core transmit handshake.
//    smp_valid/smp_data/smp_ready : byte stream into the packer
//    tx_start_en/tx_byte_num      : packet launch towards the UDP core
//    tx_req/tx_data               : word request / payload word
//    tx_done                      : packet fully transmitted
//  Modports: master = sample source + UDP core, slave = packer.
//  Revision: 1.0  initial release
// ============================================================================
interface udp_tx_packer_if;
  logic        smp_valid;
  logic [7:0]  smp_data;
  logic        smp_ready;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req;
  logic [31:0] tx_data;
  logic        tx_done;

  modport master (
    output smp_valid, smp_data, tx_req, tx_done,
    input  smp_ready, tx_start_en, tx_byte_num, tx_data
  );

  modport slave (
    input  smp_valid, smp_data, tx_req, tx_done,
    output smp_ready, tx_start_en, tx_byte_num, tx_data
  );
endinterface
`default_nettype wire

// File: rtl/sync_word_fifo.sv
`default_nettype none
// ============================================================================
//  sync_word_fifo
// ----------------------------------------------------------------------------
//  Single-clock FIFO with registered read data.
//    clk, rst          : clock, synchronous active-high reset
//    wr_en, wr_data    : push (ignored when full)
//    rd_en, rd_data    : pop (ignored when empty); rd_data valid next cycle
//    full, empty       : status
//    level             : number of stored words (0..2^AW)
//  Revision: 1.0  initial release
// ============================================================================
module sync_word_fifo #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  // Storage is not reset; only pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
      level   <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      // Simultaneous push and pop leaves the level unchanged.
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/udp_tx_packer.sv
`default_nettype none
// ============================================================================
//  udp_tx_packer
// ----------------------------------------------------------------------------
//  Packs a byte stream into network-order 32-bit words, buffers them in a
//  word FIFO and feeds fixed-size packets to a UDP transmit core.
//    sys_clk, sys_rst  : clock, synchronous active-high reset
//    pkt_en            : allow new packet launches (sampled in IDLE only)
//    bus (slave)       : sample stream in, UDP-core handshake out
//    busy              : FSM not in IDLE
//    err_underrun      : sticky, core requested more words than a packet has
//  Revision: 1.0  initial release
// ============================================================================
module udp_tx_packer
  import udp_pkg::*;
#(
  parameter int PKT_BYTES = 1024,
  parameter int FIFO_AW   = 9
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           pkt_en,
  udp_tx_packer_if.slave bus,
  output logic           busy,
  output logic           err_underrun
);
  localparam int               PKT_WORDS  = PKT_BYTES / 4;
  localparam logic [15:0]      WORDS_C    = 16'(PKT_WORDS);
  localparam logic [15:0]      LAST_C     = 16'(PKT_WORDS - 1);
  localparam logic [FIFO_AW:0] LEVEL_NEED = (FIFO_AW+1)'(PKT_WORDS);

  if (!pkt_bytes_valid(PKT_BYTES) || (PKT_WORDS > (1 << FIFO_AW))) begin : g_param_check
    $error("udp_tx_packer: PKT_BYTES must be 4..1472, a multiple of 4, and fit the FIFO");
  end

  // ---------------------------------------------------------------- packer
  logic [23:0]      pack_data;
  logic [1:0]       pack_cnt;
  logic             accept;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_level;
  logic [31:0]      fifo_rd_data;

  // Back-pressure only when the fourth byte would have nowhere to go.
  assign bus.smp_ready = ~(fifo_full && (pack_cnt == 2'd3));
  assign accept        = bus.smp_valid & bus.smp_ready;
  assign push          = accept && (pack_cnt == 2'd3);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pack_data <= '0;
      pack_cnt  <= '0;
    end else if (accept) begin
      if (pack_cnt == 2'd3) begin
        pack_cnt <= '0;
      end else begin
        pack_data <= {pack_data[15:0], bus.smp_data};
        pack_cnt  <= pack_cnt + 2'd1;
      end
    end
  end

  // ------------------------------------------------------------------ FSM
  tx_state_t   state;
  tx_state_t   state_next;
  logic [15:0] word_cnt;
  logic        pop;
  logic        req_over;
  logic        start;
  logic        data_zero;

  sync_word_fifo #(
    .AW (FIFO_AW),
    .DW (32)
  ) u_fifo (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .wr_en   (push),
    .wr_data ({pack_data, bus.smp_data}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_next = state;
    start      = 1'b0;
    pop        = 1'b0;
    req_over   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pkt_en && (fifo_level >= LEVEL_NEED)) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        start      = 1'b1;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (bus.tx_req) begin
          if (word_cnt < WORDS_C) begin
            pop = ~fifo_empty;
          end else begin
            req_over = 1'b1;
          end
        end
        // An early tx_done abandons the rest of the packet in the FIFO.
        if (bus.tx_done) begin
          state_next = ST_IDLE;
        end else if (pop && (word_cnt == LAST_C)) begin
          state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        req_over = bus.tx_req;
        if (bus.tx_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      word_cnt     <= '0;
      err_underrun <= 1'b0;
      data_zero    <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        word_cnt <= '0;
      end else if (pop) begin
        word_cnt <= word_cnt + 16'd1;
      end
      if (req_over) begin
        err_underrun <= 1'b1;
      end
      // Masks the FIFO read register so an over-request returns zero
      // with the same one-cycle latency as a real pop.
      if (req_over) begin
        data_zero <= 1'b1;
      end else if (pop) begin
        data_zero <= 1'b0;
      end
    end
  end

  assign bus.tx_start_en = start;
  assign bus.tx_byte_num = 16'(PKT_BYTES);
  assign bus.tx_data     = data_zero ? 32'd0 : fifo_rd_data;
  assign busy            = (state != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_udp_tx_packer.sv
`default_nettype none
// ============================================================================
//  tb_udp_tx_packer
// ----------------------------------------------------------------------------
//  Self-checking bench: random byte source and a behavioural UDP-core model.
//  Expected payload words are the accepted byte stream grouped in fours.
//  Revision: 1.0  initial release
// ============================================================================
module tb_udp_tx_packer;
  localparam int PKT_BYTES = 16;
  localparam int FIFO_AW   = 2;
  localparam int WORDS     = PKT_BYTES / 4;

  localparam int CP_IDLE = 0;
  localparam int CP_HDR  = 1;
  localparam int CP_REQ  = 2;
  localparam int CP_TAIL = 3;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic pkt_en  = 1'b0;
  logic busy;
  logic err_underrun;

  udp_tx_packer_if bus ();

  udp_tx_packer #(
    .PKT_BYTES (PKT_BYTES),
    .FIFO_AW   (FIFO_AW)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .pkt_en       (pkt_en),
    .bus          (bus),
    .busy         (busy),
    .err_underrun (err_underrun)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus / model state
  logic [7:0]  src_q [$];
  logic [7:0]  acc_q [$];
  int          src_gap      = 0;
  int          rst_hold     = 3;
  logic        rst_armed    = 1'b0;
  int          resets_done  = 0;
  int          rst_after_req = 0;
  logic        exp_err      = 1'b0;
  logic        start_prev   = 1'b0;
  int          starts       = 0;
  int          pkts_done    = 0;
  int          words_popped = 0;
  logic        pend_word_v  = 1'b0;
  logic [31:0] pend_word    = '0;
  logic        pend_zero    = 1'b0;
  logic        pend_idle    = 1'b0;
  logic        chk_ready_rise = 1'b0;
  int          core_ph      = CP_IDLE;
  int          core_dly     = 0;
  int          reqs_issued  = 0;
  logic        core_extra   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    if (rst_hold > 0) begin
      sys_rst = 1'b1;
      rst_hold--;
      src_q.delete();
      core_ph = CP_IDLE;
    end else begin
      sys_rst = 1'b0;
    end
    bus.smp_valid = (src_q.size() > 0) && ($urandom_range(0, 99) >= src_gap);
    bus.smp_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    bus.tx_req    = 1'b0;
    bus.tx_done   = 1'b0;
    case (core_ph)
      CP_HDR: begin
        if (core_dly == 0) core_ph = CP_REQ;
        else core_dly--;
      end
      CP_REQ: begin
        if (core_dly != 0) begin
          core_dly--;
        end else begin
          bus.tx_req = 1'b1;
          reqs_issued++;
          core_dly = $urandom_range(0, 3);
          if (reqs_issued == WORDS + (core_extra ? 1 : 0)) begin
            core_ph  = CP_TAIL;
            core_dly = $urandom_range(1, 4);
          end
        end
      end
      CP_TAIL: begin
        if (core_dly != 0) begin
          core_dly--;
        end else begin
          bus.tx_done = 1'b1;
          core_ph = CP_IDLE;
          pkts_done++;
        end
      end
      default: ;
    endcase
  endtask

  // One clock: observe at the falling edge, drive just after the rising edge.
  task automatic cycle();
    logic [31:0] w;
    @(negedge sys_clk);
    if (rst_armed) begin
      acc_q.delete();
      exp_err        = 1'b0;
      pend_word_v    = 1'b0;
      pend_zero      = 1'b0;
      pend_idle      = 1'b0;
      chk_ready_rise = 1'b0;
      start_prev     = 1'b0;
      words_popped   = 0;
      if (!sys_rst) begin
        resets_done++;
        check_eq("rst_tx_start_en", bus.tx_start_en, 0);
        check_eq("rst_tx_data", bus.tx_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err_underrun", err_underrun, 0);
        check_eq("rst_smp_ready", bus.smp_ready, 1);
        check_eq("rst_tx_byte_num", bus.tx_byte_num, PKT_BYTES);
      end
    end
    rst_armed = sys_rst;

    if (pend_word_v) begin
      check_eq("tx_word", bus.tx_data, pend_word);
      if (chk_ready_rise) begin
        check_eq("ready_after_pop", bus.smp_ready, 1);
        chk_ready_rise = 1'b0;
      end
      pend_word_v = 1'b0;
    end
    if (pend_zero) begin
      check_eq("underrun_data", bus.tx_data, 0);
      pend_zero = 1'b0;
    end
    if (pend_idle) begin
      check_eq("idle_after_done", busy, 0);
      pend_idle = 1'b0;
    end
    check_eq("err_underrun", err_underrun, exp_err);

    if (bus.tx_start_en) begin
      check_eq("start_pulse_len", start_prev, 0);
      check_eq("busy_in_start", busy, 1);
      check_eq("start_while_core_busy", core_ph, CP_IDLE);
      check_eq("tx_byte_num", bus.tx_byte_num, PKT_BYTES);
      starts++;
      core_ph      = CP_HDR;
      core_dly     = $urandom_range(0, 3);
      reqs_issued  = 0;
      words_popped = 0;
    end
    start_prev = bus.tx_start_en;

    if (bus.smp_valid && bus.smp_ready) begin
      acc_q.push_back(bus.smp_data);
      void'(src_q.pop_front());
    end

    if (bus.tx_req) begin
      if (words_popped < WORDS) begin
        if (acc_q.size() < 4) begin
          check_eq("model_bytes_available", acc_q.size(), 4);
        end else begin
          w = {acc_q[0], acc_q[1], acc_q[2], acc_q[3]};
          repeat (4) void'(acc_q.pop_front());
          pend_word   = w;
          pend_word_v = 1'b1;
        end
        words_popped++;
        if (rst_after_req != 0 && words_popped == rst_after_req) begin
          rst_hold      = 1;
          rst_after_req = 0;
        end
      end else begin
        pend_zero = 1'b1;
        exp_err   = 1'b1;
      end
    end
    if (bus.tx_done) pend_idle = 1'b1;

    @(posedge sys_clk);
    #1;
    drive_inputs();
  endtask

  task automatic run_until_pkts(input int target, input int budget);
    int n = 0;
    while (pkts_done < target && n < budget) begin
      cycle();
      n++;
    end
    if (pkts_done < target) check_eq("timeout_pkts", pkts_done, target);
  endtask

  task automatic run_until_resets(input int target, input int budget);
    int n = 0;
    while (resets_done < target && n < budget) begin
      cycle();
      n++;
    end
    if (resets_done < target) check_eq("timeout_reset", resets_done, target);
  endtask

  task automatic queue_seq(input int first, input int count);
    for (int i = 0; i < count; i++) src_q.push_back(8'(first + i));
  endtask

  task automatic queue_rand(input int count);
    for (int i = 0; i < count; i++) src_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    int s0;
    bus.smp_valid = 1'b0;
    bus.smp_data  = 8'h00;
    bus.tx_req    = 1'b0;
    bus.tx_done   = 1'b0;

    // reset
    run_until_resets(1, 20);

    // 8 bytes with launches disabled, then complete the packet and enable
    pkt_en = 1'b0;
    queue_seq(8'h01, 8);
    repeat (20) cycle();
    check_eq("no_start_pkt_en0", starts, 0);
    check_eq("accepted_8", acc_q.size(), 8);
    check_eq("busy_idle", busy, 0);
    queue_seq(8'h09, 8);
    pkt_en = 1'b1;
    run_until_pkts(pkts_done + 1, 300);

    // fresh packet 0x00..0x0F; pkt_en dropped mid-packet must not abort it
    rst_hold = 1;
    run_until_resets(resets_done + 1, 20);
    s0 = starts;
    queue_seq(8'h00, 16);
    for (int n = 0; n < 200 && starts == s0; n++) cycle();
    pkt_en = 1'b0;
    run_until_pkts(pkts_done + 1, 300);
    check_eq("one_start", starts - s0, 1);
    pkt_en = 1'b1;

    // over-request: fifth tx_req returns zero and sets the sticky error
    src_gap    = 30;
    core_extra = 1'b1;
    queue_rand(16);
    run_until_pkts(pkts_done + 1, 400);
    core_extra = 1'b0;
    repeat (8) cycle();
    check_eq("err_sticky", err_underrun, 1);
    rst_hold = 1;
    run_until_resets(resets_done + 1, 20);

    // fill FIFO to full with launches disabled, then drain
    src_gap = 0;
    pkt_en  = 1'b0;
    s0      = starts;
    queue_rand(32);
    repeat (40) cycle();
    check_eq("ready_low_when_full", bus.smp_ready, 0);
    check_eq("accepted_when_full", acc_q.size(), 19);
    check_eq("no_start_when_full", starts - s0, 0);
    chk_ready_rise = 1'b1;
    pkt_en = 1'b1;
    run_until_pkts(pkts_done + 2, 600);
    repeat (4) cycle();
    check_eq("full_src_drained", src_q.size(), 0);
    check_eq("full_model_drained", acc_q.size(), 0);

    // reset after the second tx_req, then a new packet
    src_gap = 30;
    queue_rand(16);
    rst_after_req = 2;
    run_until_resets(resets_done + 1, 400);
    s0 = starts;
    queue_rand(16);
    run_until_pkts(pkts_done + 1, 400);
    check_eq("start_after_reset", starts - s0, 1);

    // continuous stream, back-to-back packets
    src_gap = 0;
    queue_rand(160);
    run_until_pkts(pkts_done + 10, 3000);
    repeat (4) cycle();
    check_eq("b2b_src_drained", src_q.size(), 0);
    check_eq("b2b_model_drained", acc_q.size(), 0);

    repeat (5) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
